// File: rtl/memory_access_arbiter_if.sv
// Bus bundle between the fetch unit, the memory operator, the arbiter and the RAM pins.
interface memory_access_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [31:0]           if_data;

  logic                  mo_req;
  logic                  mo_we;
  logic [1:0]            mo_size;
  logic [ADDR_WIDTH-1:0] mo_addr;
  logic [31:0]           mo_wdata;
  logic                  mo_done;
  logic [31:0]           mo_rdata;

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, mo_req, mo_we, mo_size, mo_addr, mo_wdata, mem_din,
    output if_done, if_data, mo_done, mo_rdata, mem_dout, mem_a, mem_wr
  );

  // Requester / RAM side
  modport master (
    output if_req, if_addr, mo_req, mo_we, mo_size, mo_addr, mo_wdata, mem_din,
    input  if_done, if_data, mo_done, mo_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/memory_access_arbiter.sv
// memory_access_arbiter: shares the byte-wide RAM port between IF and MO,
// sequencing multi-byte little-endian accesses one byte per cycle.
// Optional macro MEM_ARB_IO_STALL_EN: stores to addr[17:16]==2'b11 wait while
// io_buffer_full is high.
module memory_access_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IF_BYTES   = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic flush_in,
  input  logic io_buffer_full,
  memory_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;
  typedef enum logic {OWN_IF, OWN_MO} owner_e;

  localparam logic [1:0] IF_LAST = 2'(IF_BYTES - 1);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            last_q, last_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           data_q, data_d;
  logic                  if_done_q, if_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic                  mo_done_q, mo_done_d;
  logic [31:0]           mo_rdata_q, mo_rdata_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;

  logic       io_hold;
  logic       mo_io_block;
  logic       mo_ok;
  logic       if_ok;
  logic [1:0] mo_last;
  logic [1:0] cnt_nxt;
  logic       try_grant;

`ifdef MEM_ARB_IO_STALL_EN
  // IO-region stores wait for room in the UART buffer, both at grant and mid-transfer.
  assign io_hold     = (state_q == WRITE) && (addr_q[17:16] == 2'b11) && io_buffer_full;
  assign mo_io_block = bus.mo_we && (bus.mo_addr[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full;
  assign io_hold        = 1'b0;
  assign mo_io_block    = 1'b0;
`endif

  // A requester still seeing its done pulse is treated as not requesting.
  assign mo_ok   = bus.mo_req && !mo_done_q && !mo_io_block;
  assign if_ok   = bus.if_req && !if_done_q && !flush_in;
  assign mo_last = (bus.mo_size == 2'd0) ? 2'd0 : (bus.mo_size == 2'd1) ? 2'd1 : 2'd3;
  assign cnt_nxt = cnt_q + 2'd1;

  // Next-state, byte sequencing, grant and completion.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    if_done_d  = if_done_q;
    if_data_d  = if_data_q;
    mo_done_d  = mo_done_q;
    mo_rdata_d = mo_rdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    try_grant  = 1'b0;

    if (rdy_in && !io_hold) begin
      if_done_d = 1'b0;
      mo_done_d = 1'b0;

      case (state_q)
        IDLE: try_grant = 1'b1;

        READ: begin
          if (owner_q == OWN_IF && flush_in) begin
            state_d   = IDLE;
            cnt_d     = 2'd0;
            mem_a_d   = '0;
            try_grant = 1'b1;
          end else begin
            data_d[{cnt_q, 3'b000} +: 8] = bus.mem_din;
            if (cnt_q < last_q) begin
              cnt_d   = cnt_nxt;
              mem_a_d = addr_q + ADDR_WIDTH'(cnt_nxt);
            end else begin
              state_d = IDLE;
              cnt_d   = 2'd0;
              mem_a_d = '0;
              if (owner_q == OWN_IF) begin
                if_done_d = 1'b1;
                if_data_d = data_d;
              end else begin
                mo_done_d  = 1'b1;
                mo_rdata_d = data_d;
              end
            end
          end
        end

        WRITE: begin
          if (cnt_q < last_q) begin
            cnt_d      = cnt_nxt;
            mem_a_d    = addr_q + ADDR_WIDTH'(cnt_nxt);
            mem_dout_d = wdata_q[{cnt_nxt, 3'b000} +: 8];
          end else begin
            state_d   = IDLE;
            cnt_d     = 2'd0;
            mem_a_d   = '0;
            mem_wr_d  = 1'b0;
            mo_done_d = 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase

      if (try_grant) begin
        if (mo_ok) begin
          owner_d = OWN_MO;
          addr_d  = bus.mo_addr;
          last_d  = mo_last;
          wdata_d = bus.mo_wdata;
          data_d  = 32'd0;
          cnt_d   = 2'd0;
          mem_a_d = bus.mo_addr;
          if (bus.mo_we) begin
            state_d    = WRITE;
            mem_wr_d   = 1'b1;
            mem_dout_d = bus.mo_wdata[7:0];
          end else begin
            state_d  = READ;
            mem_wr_d = 1'b0;
          end
        end else if (if_ok) begin
          owner_d  = OWN_IF;
          addr_d   = bus.if_addr;
          last_d   = IF_LAST;
          data_d   = 32'd0;
          cnt_d    = 2'd0;
          mem_a_d  = bus.if_addr;
          mem_wr_d = 1'b0;
          state_d  = READ;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      last_q     <= 2'd0;
      cnt_q      <= 2'd0;
      wdata_q    <= 32'd0;
      data_q     <= 32'd0;
      if_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      mo_done_q  <= 1'b0;
      mo_rdata_q <= 32'd0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      mo_done_q  <= mo_done_d;
      mo_rdata_q <= mo_rdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign bus.if_done  = if_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.mo_done  = mo_done_q;
  assign bus.mo_rdata = mo_rdata_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  // Write strobe is suppressed immediately whenever the transfer is paused.
  assign bus.mem_wr   = mem_wr_q & rdy_in & ~io_hold;

endmodule

// File: doc/memory_access_arbiter.md
Name: memory_access_arbiter

Overview:
- Shares the single byte-wide RAM port between the instruction fetcher (IF) and the memory operator (MO).
- Sequences each multi-byte access as consecutive byte cycles and assembles or splits little-endian data.
- Returns one-cycle done pulses to the requester that owns the current transaction.
- Sits between the fetch unit / memory operator and the top-level RAM pins; is aborted for IF by the CentralScheduleUnit flush.

Parameters:
- ADDR_WIDTH, 32, width of all byte addresses.
- IF_BYTES, 4, bytes per instruction fetch; legal values 2 or 4.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-high.
- rdy_in  input  1  global ready; pause when low.
- flush_in  input  1  pipeline flush from the CSU.
- if_req  input  1  fetch request; level, held until if_done.
- if_addr  input  ADDR_WIDTH  fetch byte address.
- if_done  output  1  one-cycle pulse; if_data is valid in the same cycle.
- if_data  output  32  fetched bytes, little-endian; upper bits zero when IF_BYTES=2.
- mo_req  input  1  memory-operator request; level, held until mo_done.
- mo_we  input  1  1 = store, 0 = load.
- mo_size  input  2  0 = byte, 1 = half, 2 or 3 = word.
- mo_addr  input  ADDR_WIDTH  access byte address.
- mo_wdata  input  32  store data; low bytes are used.
- mo_done  output  1  one-cycle completion pulse.
- mo_rdata  output  32  load data, zero-extended (MO performs sign extension).
- mem_din  input  8  RAM read data.
- mem_dout  output  8  RAM write data.
- mem_a  output  ADDR_WIDTH  RAM address.
- mem_wr  output  1  RAM write enable.
- io_buffer_full  input  1  UART buffer full.

Behaviour:
- Reset (async, rst_in=1): state=IDLE, all outputs 0, internal counters 0.
- States: IDLE, READ, WRITE. Owner register selects IF or MO.
- N = IF_BYTES for IF; for MO, N = 1, 2 or 4 from mo_size.
- RAM timing: mem_din at edge k+1 holds the byte addressed by mem_a during cycle k.
- IDLE grant, on an edge with rdy_in=1:
  - A requester whose done is high in that cycle is ignored.
  - MO wins over IF.
  - IF is not granted while flush_in=1.
  - Latch address, N and wdata; cnt=0; mem_a=addr.
  - Load or fetch: mem_wr=0, go to READ.
  - Store: mem_wr=1, mem_dout=wdata[7:0], go to WRITE.
- READ, each edge:
  - data[8*cnt+:8]=mem_din.
  - If cnt<N-1: cnt+1, mem_a=addr+cnt+1.
  - Else: owner done=1, data output updated, mem_a=0, go to IDLE.
- WRITE, each edge:
  - If cnt<N-1: cnt+1, mem_a=addr+cnt+1, mem_dout=next byte.
  - Else: mem_wr=0, mem_a=0, done=1, go to IDLE.
- Latency: done is high in the cycle after the N-th edge following the grant edge. A word access occupies 4 RAM cycles.
- Throughput: a new grant is possible on the edge that ends the done cycle.
- Address arithmetic is modulo 2^ADDR_WIDTH; 0xFFFFFFFF+1 wraps to 0.
- done pulses last exactly 1 cycle. if_data and mo_rdata hold their value until the next completion.
- rdy_in=0: every register holds. mem_wr output is combinationally forced 0. Because mem_a is held, the read byte is re-fetched, so the byte captured after resume is correct.
- flush_in=1 at an edge while owner=IF and state=READ: abort. Go to IDLE, mem_a=0, no if_done. The same edge may not grant IF, but may grant MO.
- flush_in does not affect MO transactions; stores always complete.
- Simultaneous flush and IF last byte: abort wins, no if_done.

Optional Feature:
- Macro MEM_ARB_IO_STALL_EN.
- Defined:
  - A store with addr[17:16]==2'b11 is not granted while io_buffer_full=1.
  - A WRITE in progress to that region holds, with mem_wr forced 0, while io_buffer_full=1.
  - It resumes the cycle after io_buffer_full drops.
- Not defined: io_buffer_full is ignored (port kept, unused).

Test Plan:
- IF fetch at 0x1000, RAM bytes 13 05 00 00 -> mem_a 0x1000, 0x1001, 0x1002, 0x1003 on consecutive cycles; if_done 1 cycle, 4 edges after grant; if_data=0x00000513.
- if_req (0x1000) and mo_req (load byte 0x2000, RAM=0x9C) in the same cycle -> MO first; mo_done after 1 edge with mo_rdata=0x0000009C; IF granted the edge after mo_done; 4 edges later if_done.
- MO store half 0xABCD at 0xFFFFFFFF -> mem_wr high 2 cycles; mem_a 0xFFFFFFFF then 0x00000000; mem_dout 0xCD then 0xAB; then mo_done.
- flush_in pulse after 2 IF bytes, mo_req pending -> no if_done; MO granted on the flush edge; no further IF-address cycles.
- rdy_in low 3 cycles during word load at 0x3000 (bytes 11 22 33 44) -> no state change while low; mo_rdata=0x44332211; mo_done 3 cycles later than nominal.
- MEM_ARB_IO_STALL_EN defined: store byte 0x41 to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0; exactly one write of 0x41 after io_buffer_full falls; then mo_done.
